udp_rx_frame_unpack: RTL and testbench
======================================

Name: udp_rx_frame_unpack

Overview:
Receive-side counterpart of the ADC/UDP transmit packer, running in the udp_clk domain. It consumes 128-bit UDP payload words framed by sof/eof and classifies each frame as calibration, message or acquisition. Calibration frames are reassembled into per-channel baseline/noise. Message frames yield the fee_mode, and acquisition frames are streamed out with package-counter sequence checking. Used in the loopback/self-test path and by the slow-control side that monitors FEE frames.

Parameters:
ADC_CHANEL, 8, number of ADC channels
DATAWIDTH, 16, bits per channel field; one payload word = ADC_CHANEL*DATAWIDTH bits
CNT_WIDTH, 11, package counter width in acquisition header word

Ports:
udp_clk  in  1  clock
sys_rst  in  1  asynchronous, active-high reset
rx_valid  in  1  rx_data/rx_sof/rx_eof valid this cycle (no backpressure)
rx_sof  in  1  first word of frame
rx_eof  in  1  last word of frame
rx_data  in  ADC_CHANEL*DATAWIDTH  payload word
baseline_out  out  ADC_CHANEL*DATAWIDTH  channel i at [i*DATAWIDTH +: DATAWIDTH]
noise_out  out  ADC_CHANEL*DATAWIDTH  same layout
cal_valid  out  1  1-cycle pulse: baseline_out/noise_out updated
fee_mode_out  out  5  last received fee_mode
msg_valid  out  1  1-cycle pulse: fee_mode_out updated
acq_data  out  ADC_CHANEL*DATAWIDTH  acquisition data word
acq_valid  out  1  acq_data valid
acq_last  out  1  with acq_valid, last word of frame
pkt_cnt_out  out  CNT_WIDTH  header count of current acquisition frame
seq_err  out  1  pulse: package count not previous+1
frame_err  out  1  pulse: length/marker violation, frame dropped

Behaviour:
- Reset is asynchronous and active-high (sys_rst). All outputs reset to 0, state returns to IDLE, and the count-seen flag is cleared. Reset mid-frame discards the partial frame with no error pulse.
- Frame layout: 3-word frames form a 3*ADC_CHANEL*DATAWIDTH buffer. Word k occupies buf[k*W +: W]. Channel i slot = buf[i*3*DATAWIDTH +: 3*DATAWIDTH] = {f2, f1, marker}, with marker in the low DATAWIDTH bits.
- Classification on rx_valid & rx_sof (word 0):
  - CAL if word0[15:0] and word0[63:48] == 16'h3456.
  - MSG if both == 16'h0666.
  - Otherwise ACQ.
  - Both slot markers are required because an 11-bit count can equal 0x0666.
- States: IDLE, CAL, MSG, ACQ, DROP. Words with rx_valid=0 are ignored.
- CAL/MSG:
  - Store word 0 and set word index = 1.
  - Word 1 without eof: store it.
  - Word 2 with eof: commit, return to IDLE.
  - eof on word 0 or 1: frame_err, no update, go to IDLE.
  - Word 2 without eof: frame_err, go to DROP.
- CAL commit: every channel marker must be 0x3456, else frame_err and no update. On pass, baseline_out[i] = slot f2 and noise_out[i] = slot f1; cal_valid pulses 1 cycle after word 2 is accepted.
- MSG commit: every marker must be 0x0666, f2 == 0, and f1[15:5] == 0. fee_mode_out = channel 0 f1[4:0], and all channels must carry the same value, else frame_err. On pass, msg_valid pulses 1 cycle after word 2.
- ACQ header:
  - pkt_cnt_out <= word0[CNT_WIDTH-1:0].
  - If count-seen and value != (last+1) mod 2^CNT_WIDTH: seq_err pulse, next cycle.
  - last <= value; count-seen <= 1. A wrap from 2047 to 0 is legal.
  - Header with eof: go to IDLE, no acq_valid.
- ACQ data: each subsequent word is registered to acq_data with acq_valid one cycle later. acq_last = rx_eof; eof returns to IDLE.
- DROP: discard until eof, then go to IDLE.
- rx_sof while not in IDLE: pulse frame_err for the aborted frame, then classify the new word normally in the same cycle. A partial CAL/MSG buffer is never committed.
- rx_valid without sof in IDLE: ignore, no error.
- rx_sof & rx_eof on the same word: single-word frame. ACQ counts as a header only; CAL/MSG give frame_err.
- All error/valid pulses are registered, 1-cycle wide, and may coincide (e.g. frame_err + seq_err on an abort followed by a bad header).

Decomposition:
- Shared package daq_pkt_pkg holds:
  - CALIBRATION_MARKER 16'h3456 and MESSAGE_MARKER 16'h0666
  - MODE_*/STAT_* codes, shared with the transmit packer
  - frame-type enum (CAL/MSG/ACQ) and state encoding
- Sub-module pkt_slot_check (combinational): takes the 3-word buffer and the expected marker. It returns all_marker_ok, msg_fields_ok and fee_mode_consistent. Instantiated once, selected by state.

Test Plan:
- CAL frame, channel i baseline=16'h0100+i, noise=16'h0010+i, markers 0x3456, eof on word 2 -> cal_valid one pulse; baseline_out[7]=16'h0107, noise_out[0]=16'h0010.
- MSG frame with fee_mode=5'd2 in all slots -> msg_valid pulse, fee_mode_out=2. Repeat with channel 3 fee_mode=1 -> frame_err, fee_mode_out stays 2.
- ACQ headers 2046, 2047, 0 each followed by 4 data words -> no seq_err, 4 acq_valid per frame, acq_last on 4th. Next header 2 -> seq_err pulse, pkt_cnt_out=2.
- ACQ header 0x0666 (ch1 marker slot = 0) -> classified ACQ, no msg_valid.
- CAL frame with eof on word 1 -> frame_err, baseline_out unchanged. CAL frame with sof on a new word mid-frame -> frame_err, new frame decoded correctly.
- sys_rst asserted mid-CAL after word 1 -> all outputs 0 immediately, no cal_valid. Next ACQ header 5 -> no seq_err (count-seen cleared).

Source files
------------

// File: rtl/daq_pkt_pkg.sv
// rtl/daq_pkt_pkg.sv - shared DAQ packet constants, frame types and rx state encoding
// Contents:
//   CALIBRATION_MARKER / MESSAGE_MARKER : per-channel slot markers
//   MODE_* / STAT_*                     : fee_mode and status codes shared with the tx packer
//   frame_type_t                        : classification of an incoming frame
//   rx_state_t                          : udp_rx_frame_unpack state encoding
//   classify_frame()                    : word-0 classification from the ch0/ch1 marker slots
package daq_pkt_pkg;

  localparam logic [15:0] CALIBRATION_MARKER = 16'h3456;
  localparam logic [15:0] MESSAGE_MARKER     = 16'h0666;

  localparam logic [4:0] MODE_ACQ      = 5'd0;
  localparam logic [4:0] MODE_CAL      = 5'd1;
  localparam logic [4:0] MODE_SELFTEST = 5'd2;
  localparam logic [4:0] MODE_IDLE     = 5'd3;

  localparam logic [1:0] STAT_OK       = 2'd0;
  localparam logic [1:0] STAT_BUSY     = 2'd1;
  localparam logic [1:0] STAT_ERR      = 2'd2;

  typedef enum logic [1:0] {
    FT_CAL,
    FT_MSG,
    FT_ACQ
  } frame_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_MSG,
    ST_ACQ,
    ST_DROP
  } rx_state_t;

  // Both channel-0 and channel-1 marker slots must agree: an 11-bit
  // acquisition count can alias the message marker in the channel-0 slot.
  function automatic frame_type_t classify_frame(input logic [15:0] mark0,
                                                 input logic [15:0] mark1);
    if (mark0 == CALIBRATION_MARKER && mark1 == CALIBRATION_MARKER)
      return FT_CAL;
    else if (mark0 == MESSAGE_MARKER && mark1 == MESSAGE_MARKER)
      return FT_MSG;
    else
      return FT_ACQ;
  endfunction

endpackage

// File: rtl/pkt_slot_check.sv
// rtl/pkt_slot_check.sv - combinational per-channel slot checker for 3-word frames
// Ports:
//   frame_buf           in  3-word frame buffer, channel i slot = {f2, f1, marker}
//   marker              in  marker every channel slot must carry
//   all_marker_ok       out every slot marker equals marker
//   msg_fields_ok       out every slot has f2 == 0 and f1 upper bits (above fee_mode) == 0
//   fee_mode_consistent out every slot f1[4:0] equals channel 0 f1[4:0]
//   fee_mode            out channel 0 f1[4:0]
module pkt_slot_check
  import daq_pkt_pkg::*;
#(
  parameter int ADC_CHANEL = 8,
  parameter int DATAWIDTH  = 16
) (
  input  logic [3*ADC_CHANEL*DATAWIDTH-1:0] frame_buf,
  input  logic [DATAWIDTH-1:0]              marker,
  output logic                              all_marker_ok,
  output logic                              msg_fields_ok,
  output logic                              fee_mode_consistent,
  output logic [4:0]                        fee_mode
);

  localparam int SLOT_W = 3 * DATAWIDTH;

  logic [SLOT_W-1:0] slot;

  always_comb begin
    all_marker_ok       = 1'b1;
    msg_fields_ok       = 1'b1;
    fee_mode_consistent = 1'b1;
    fee_mode            = frame_buf[DATAWIDTH +: 5];
    slot                = '0;
    for (int i = 0; i < ADC_CHANEL; i++) begin
      slot = frame_buf[i*SLOT_W +: SLOT_W];
      if (slot[DATAWIDTH-1:0] != marker)
        all_marker_ok = 1'b0;
      if (slot[3*DATAWIDTH-1:2*DATAWIDTH] != '0 ||
          slot[2*DATAWIDTH-1:DATAWIDTH+5] != '0)
        msg_fields_ok = 1'b0;
      if (slot[DATAWIDTH +: 5] != fee_mode)
        fee_mode_consistent = 1'b0;
    end
  end

endmodule

// File: rtl/udp_rx_frame_unpack.sv
// rtl/udp_rx_frame_unpack.sv - classify and unpack received CAL/MSG/ACQ UDP payload frames
// Ports:
//   udp_clk, sys_rst        clock, asynchronous active-high reset
//   rx_valid/sof/eof/data   framed payload words, no backpressure
//   baseline_out/noise_out  per-channel calibration results, cal_valid pulse on update
//   fee_mode_out, msg_valid last message fee_mode, pulse on update
//   acq_data/valid/last     acquisition data stream, one cycle behind rx
//   pkt_cnt_out, seq_err    acquisition header count, pulse on non-consecutive count
//   frame_err               pulse on length/marker violation (frame dropped)
module udp_rx_frame_unpack
  import daq_pkt_pkg::*;
#(
  parameter int ADC_CHANEL = 8,
  parameter int DATAWIDTH  = 16,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                           udp_clk,
  input  logic                           sys_rst,
  input  logic                           rx_valid,
  input  logic                           rx_sof,
  input  logic                           rx_eof,
  input  logic [ADC_CHANEL*DATAWIDTH-1:0] rx_data,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] baseline_out,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] noise_out,
  output logic                           cal_valid,
  output logic [4:0]                     fee_mode_out,
  output logic                           msg_valid,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] acq_data,
  output logic                           acq_valid,
  output logic                           acq_last,
  output logic [CNT_WIDTH-1:0]           pkt_cnt_out,
  output logic                           seq_err,
  output logic                           frame_err
);

  localparam int W      = ADC_CHANEL * DATAWIDTH;
  localparam int SLOT_W = 3 * DATAWIDTH;

  rx_state_t         state, state_next;
  logic [1:0]        word_idx, word_idx_next;
  logic [W-1:0]      word0, word1;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic              cnt_seen;

  logic              store0, store1, do_cal, do_msg, hdr, data_word;
  logic              frame_err_next, seq_err_next;
  frame_type_t       ftype;

  // Word 2 is checked straight off the bus so the commit happens on the
  // cycle it is accepted; only words 0 and 1 need storage.
  logic [3*W-1:0]    check_buf;
  logic [DATAWIDTH-1:0] exp_marker;
  logic              all_marker_ok, msg_fields_ok, fee_mode_consistent;
  logic [4:0]        fee_mode;
  logic [W-1:0]      baseline_next, noise_next;
  logic [CNT_WIDTH-1:0] rx_cnt, exp_cnt;

  assign check_buf  = {rx_data, word1, word0};
  assign exp_marker = (state == ST_MSG) ? DATAWIDTH'(MESSAGE_MARKER)
                                        : DATAWIDTH'(CALIBRATION_MARKER);
  assign ftype      = classify_frame(16'(rx_data[DATAWIDTH-1:0]),
                                     16'(rx_data[3*DATAWIDTH +: DATAWIDTH]));
  assign rx_cnt     = rx_data[CNT_WIDTH-1:0];
  assign exp_cnt    = last_cnt + 1'b1;

  pkt_slot_check #(
    .ADC_CHANEL (ADC_CHANEL),
    .DATAWIDTH  (DATAWIDTH)
  ) u_slot_check (
    .frame_buf           (check_buf),
    .marker              (exp_marker),
    .all_marker_ok       (all_marker_ok),
    .msg_fields_ok       (msg_fields_ok),
    .fee_mode_consistent (fee_mode_consistent),
    .fee_mode            (fee_mode)
  );

  always_comb begin
    baseline_next = '0;
    noise_next    = '0;
    for (int i = 0; i < ADC_CHANEL; i++) begin
      baseline_next[i*DATAWIDTH +: DATAWIDTH] = check_buf[i*SLOT_W + 2*DATAWIDTH +: DATAWIDTH];
      noise_next[i*DATAWIDTH +: DATAWIDTH]    = check_buf[i*SLOT_W + DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge udp_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      word_idx <= 2'd0;
    end else begin
      state    <= state_next;
      word_idx <= word_idx_next;
    end
  end

  always_comb begin
    state_next     = state;
    word_idx_next  = word_idx;
    store0         = 1'b0;
    store1         = 1'b0;
    do_cal         = 1'b0;
    do_msg         = 1'b0;
    hdr            = 1'b0;
    data_word      = 1'b0;
    frame_err_next = 1'b0;
    if (rx_valid) begin
      if (rx_sof) begin
        // A new sof aborts whatever was in flight, then is decoded as usual.
        if (state != ST_IDLE)
          frame_err_next = 1'b1;
        case (ftype)
          FT_CAL, FT_MSG: begin
            if (rx_eof) begin
              frame_err_next = 1'b1;
              state_next     = ST_IDLE;
            end else begin
              store0        = 1'b1;
              word_idx_next = 2'd1;
              state_next    = (ftype == FT_CAL) ? ST_CAL : ST_MSG;
            end
          end
          default: begin
            hdr        = 1'b1;
            state_next = rx_eof ? ST_IDLE : ST_ACQ;
          end
        endcase
      end else begin
        case (state)
          ST_CAL, ST_MSG: begin
            if (word_idx == 2'd1) begin
              if (rx_eof) begin
                frame_err_next = 1'b1;
                state_next     = ST_IDLE;
              end else begin
                store1        = 1'b1;
                word_idx_next = 2'd2;
              end
            end else begin
              if (rx_eof) begin
                state_next = ST_IDLE;
                if (state == ST_CAL) begin
                  if (all_marker_ok) do_cal = 1'b1;
                  else               frame_err_next = 1'b1;
                end else begin
                  if (all_marker_ok && msg_fields_ok && fee_mode_consistent) do_msg = 1'b1;
                  else                                                       frame_err_next = 1'b1;
                end
              end else begin
                frame_err_next = 1'b1;
                state_next     = ST_DROP;
              end
            end
          end
          ST_ACQ: begin
            data_word = 1'b1;
            if (rx_eof)
              state_next = ST_IDLE;
          end
          ST_DROP: begin
            if (rx_eof)
              state_next = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign seq_err_next = hdr && cnt_seen && (rx_cnt != exp_cnt);

  always_ff @(posedge udp_clk or posedge sys_rst) begin
    if (sys_rst) begin
      word0        <= '0;
      word1        <= '0;
      baseline_out <= '0;
      noise_out    <= '0;
      cal_valid    <= 1'b0;
      fee_mode_out <= '0;
      msg_valid    <= 1'b0;
      acq_data     <= '0;
      acq_valid    <= 1'b0;
      acq_last     <= 1'b0;
      pkt_cnt_out  <= '0;
      last_cnt     <= '0;
      cnt_seen     <= 1'b0;
      seq_err      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      cal_valid <= do_cal;
      msg_valid <= do_msg;
      acq_valid <= data_word;
      acq_last  <= data_word & rx_eof;
      seq_err   <= seq_err_next;
      frame_err <= frame_err_next;
      if (store0) word0 <= rx_data;
      if (store1) word1 <= rx_data;
      if (do_cal) begin
        baseline_out <= baseline_next;
        noise_out    <= noise_next;
      end
      if (do_msg)
        fee_mode_out <= fee_mode;
      if (data_word)
        acq_data <= rx_data;
      if (hdr) begin
        pkt_cnt_out <= rx_cnt;
        last_cnt    <= rx_cnt;
        cnt_seen    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_unpack.sv
// tb/tb_udp_rx_frame_unpack.sv - scoreboard bench for udp_rx_frame_unpack
module tb_udp_rx_frame_unpack;
  import daq_pkt_pkg::*;

  localparam int W = 128;

  logic           udp_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic           rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [W-1:0]   rx_data = '0;
  logic [W-1:0]   baseline_out, noise_out, acq_data;
  logic           cal_valid, msg_valid, acq_valid, acq_last, seq_err, frame_err;
  logic [4:0]     fee_mode_out;
  logic [10:0]    pkt_cnt_out;

  udp_rx_frame_unpack dut (
    .udp_clk      (udp_clk),
    .sys_rst      (sys_rst),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_data      (rx_data),
    .baseline_out (baseline_out),
    .noise_out    (noise_out),
    .cal_valid    (cal_valid),
    .fee_mode_out (fee_mode_out),
    .msg_valid    (msg_valid),
    .acq_data     (acq_data),
    .acq_valid    (acq_valid),
    .acq_last     (acq_last),
    .pkt_cnt_out  (pkt_cnt_out),
    .seq_err      (seq_err),
    .frame_err    (frame_err)
  );

  always #5 udp_clk = ~udp_clk;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_ferr = 0, obs_ferr = 0;
  int exp_serr = 0, obs_serr = 0;
  logic        m_seen = 1'b0;
  logic [10:0] m_last = '0;
  logic [W-1:0] exp_base = '0;

  logic [W-1:0] cal_base_q[$];
  logic [W-1:0] cal_noise_q[$];
  logic [4:0]   msg_q[$];
  logic [W:0]   acq_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge udp_clk) begin
    if (!sys_rst) begin
      if (frame_err) obs_ferr++;
      if (seq_err)   obs_serr++;
      if (cal_valid) begin
        if (cal_base_q.size() > 0) begin
          check_eq("cal_baseline", baseline_out, cal_base_q.pop_front());
          check_eq("cal_noise", noise_out, cal_noise_q.pop_front());
        end else
          check_eq("cal_extra", W'(cal_valid), '0);
      end
      if (msg_valid) begin
        if (msg_q.size() > 0)
          check_eq("msg_fee_mode", W'(fee_mode_out), W'(msg_q.pop_front()));
        else
          check_eq("msg_extra", W'(msg_valid), '0);
      end
      if (acq_valid) begin
        if (acq_q.size() > 0) begin
          logic [W:0] e;
          e = acq_q.pop_front();
          check_eq("acq_data", acq_data, e[W-1:0]);
          check_eq("acq_last", W'(acq_last), W'(e[W]));
        end else
          check_eq("acq_extra", W'(acq_valid), '0);
      end
    end
  end

  task automatic send_word(input logic sof, input logic eof, input logic [W-1:0] d);
    @(posedge udp_clk); #1;
    rx_valid = 1'b1; rx_sof = sof; rx_eof = eof; rx_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge udp_clk); #1;
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    end
  endtask

  function automatic logic [3*W-1:0] mk_buf(input logic [W-1:0] marks,
                                            input logic [W-1:0] f1s,
                                            input logic [W-1:0] f2s);
    logic [3*W-1:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      b[i*48 +: 48] = {f2s[i*16 +: 16], f1s[i*16 +: 16], marks[i*16 +: 16]};
    return b;
  endfunction

  function automatic logic [W-1:0] rep16(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic send3(input logic [3*W-1:0] b);
    send_word(1'b1, 1'b0, b[W-1:0]);
    send_word(1'b0, 1'b0, b[2*W-1:W]);
    send_word(1'b0, 1'b1, b[3*W-1:2*W]);
  endtask

  task automatic send_acq(input logic [10:0] cnt, input int nwords);
    logic [W-1:0] d;
    if (m_seen && cnt != 11'(m_last + 11'd1)) exp_serr++;
    m_last = cnt;
    m_seen = 1'b1;
    send_word(1'b1, nwords == 0, W'(cnt));
    for (int k = 0; k < nwords; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      acq_q.push_back({k == nwords - 1, d});
      send_word(1'b0, k == nwords - 1, d);
    end
  endtask

  task automatic checkpoint(input string tag);
    idle(3);
    check_eq({tag, "_frame_err"}, W'(obs_ferr), W'(exp_ferr));
    check_eq({tag, "_seq_err"}, W'(obs_serr), W'(exp_serr));
  endtask

  logic [W-1:0] base1, noise1, base2, noise2, f1m;
  logic [3*W-1:0] cal1, cal2, msg_ok, msg_bad;

  initial begin
    for (int i = 0; i < 8; i++) begin
      base1[i*16 +: 16]  = 16'h0100 + 16'(i);
      noise1[i*16 +: 16] = 16'h0010 + 16'(i);
      base2[i*16 +: 16]  = 16'h0200 + 16'(i);
      noise2[i*16 +: 16] = 16'h0020 + 16'(i);
    end
    cal1   = mk_buf(rep16(CALIBRATION_MARKER), noise1, base1);
    cal2   = mk_buf(rep16(CALIBRATION_MARKER), noise2, base2);
    msg_ok = mk_buf(rep16(MESSAGE_MARKER), rep16(16'd2), '0);
    f1m    = rep16(16'd2);
    f1m[3*16 +: 16] = 16'd1;
    msg_bad = mk_buf(rep16(MESSAGE_MARKER), f1m, '0);

    #2;
    check_eq("rst_outputs", baseline_out | noise_out | acq_data, '0);
    check_eq("rst_flags", W'({fee_mode_out, pkt_cnt_out, cal_valid, msg_valid,
                              acq_valid, acq_last, seq_err, frame_err}), '0);
    repeat (2) @(posedge udp_clk);
    #2 sys_rst = 1'b0;

    // calibration frame
    cal_base_q.push_back(base1); cal_noise_q.push_back(noise1);
    send3(cal1);
    checkpoint("cal1");
    exp_base = base1;
    check_eq("base_ch7", W'(baseline_out[7*16 +: 16]), W'(16'h0107));
    check_eq("noise_ch0", W'(noise_out[15:0]), W'(16'h0010));

    // message frames: good then inconsistent fee_mode
    msg_q.push_back(5'd2);
    send3(msg_ok);
    checkpoint("msg_ok");
    send3(msg_bad);
    exp_ferr++;
    checkpoint("msg_bad");
    check_eq("fee_mode_kept", W'(fee_mode_out), W'(5'd2));

    // acquisition counts across the wrap, then a gap
    send_acq(11'd2046, 4);
    send_acq(11'd2047, 4);
    send_acq(11'd0, 4);
    checkpoint("acq_wrap");
    send_acq(11'd2, 4);
    checkpoint("acq_gap");
    check_eq("pkt_cnt_2", W'(pkt_cnt_out), W'(11'd2));

    // count equal to the message marker in ch0 slot only
    send_acq(11'h666, 2);
    checkpoint("acq_666");
    check_eq("pkt_cnt_666", W'(pkt_cnt_out), W'(11'h666));

    // header-only acquisition frame
    send_acq(11'h667, 0);
    checkpoint("acq_hdr_only");

    // calibration frame cut short at word 1
    send_word(1'b1, 1'b0, cal2[W-1:0]);
    send_word(1'b0, 1'b1, cal2[2*W-1:W]);
    exp_ferr++;
    checkpoint("cal_short");
    check_eq("base_kept", baseline_out, exp_base);

    // calibration frame aborted by a new sof
    send_word(1'b1, 1'b0, cal1[W-1:0]);
    send_word(1'b0, 1'b0, cal1[2*W-1:W]);
    exp_ferr++;
    cal_base_q.push_back(base2); cal_noise_q.push_back(noise2);
    send3(cal2);
    checkpoint("cal_abort");
    exp_base = base2;
    check_eq("base_new", baseline_out, exp_base);

    // reset in the middle of a calibration frame
    send_word(1'b1, 1'b0, cal1[W-1:0]);
    send_word(1'b0, 1'b0, cal1[2*W-1:W]);
    @(posedge udp_clk); #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    sys_rst = 1'b1;
    #1;
    check_eq("midrst_outputs", baseline_out | noise_out | acq_data, '0);
    check_eq("midrst_flags", W'({fee_mode_out, pkt_cnt_out, cal_valid, msg_valid,
                                 acq_valid, acq_last, seq_err, frame_err}), '0);
    repeat (2) @(posedge udp_clk);
    #2 sys_rst = 1'b0;
    m_seen = 1'b0;
    send_acq(11'd5, 2);
    checkpoint("post_rst");
    check_eq("pkt_cnt_5", W'(pkt_cnt_out), W'(11'd5));

    idle(4);
    check_eq("cal_q_left", W'(cal_base_q.size()), '0);
    check_eq("msg_q_left", W'(msg_q.size()), '0);
    check_eq("acq_q_left", W'(acq_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
